// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer: fixed-point format,
// saturation limits, sizing constants and FSM state encoding.
package mac_sequencer_pkg;

    localparam int WIDTH   = 16;
    localparam int FRAC    = 7;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 24;

    localparam logic [WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_CLR  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ACCUM     = 3'd4,
        ST_OUTPUT    = 3'd5
    } state_e;

    // A WIDTH+1 bit sum is out of WIDTH range when its two top bits differ.
    function automatic logic sum_out_of_range(input logic [WIDTH:0] wide_sum);
        return wide_sum[WIDTH] ^ wide_sum[WIDTH-1];
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Bundle of the operand stream, multiplier handshake and result stream.
// slave: the sequencer's view. master: the environment (source, multiplier, sink).
interface mac_sequencer_if;
    import mac_sequencer_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;

    logic             mul_start;
    logic [WIDTH-1:0] mul_multiplicand;
    logic [WIDTH-1:0] mul_multiplier;
    logic [WIDTH-1:0] mul_result;
    logic             mul_overflow;
    logic             mul_finish;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_overflow;
    logic             out_error;
    logic [CNT_W-1:0] out_count;

    modport slave (
        input  in_valid, in_a, in_b, in_last,
        output in_ready,
        output mul_start, mul_multiplicand, mul_multiplier,
        input  mul_result, mul_overflow, mul_finish,
        output out_valid, out_sum, out_overflow, out_error, out_count,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_last,
        input  in_ready,
        input  mul_start, mul_multiplicand, mul_multiplier,
        output mul_result, mul_overflow, mul_finish,
        input  out_valid, out_sum, out_overflow, out_error, out_count,
        output out_ready
    );

endinterface

// File: rtl/mac_sequencer_sat_adder.sv
// Combinational signed adder that clamps to the WIDTH-bit two's complement
// range and reports when clamping happened.
module mac_sequencer_sat_adder
    import mac_sequencer_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_sat
);

    logic [WIDTH:0] w_wide;

    assign w_wide = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};

    // Clamp toward the sign of the true (WIDTH+1 bit) sum when it overflows.
    always_comb begin
        o_sum = w_wide[WIDTH-1:0];
        o_sat = 1'b0;
        if (sum_out_of_range(w_wide)) begin
            o_sat = 1'b1;
            if (w_wide[WIDTH]) begin
                o_sum = SAT_MIN;
            end else begin
                o_sum = SAT_MAX;
            end
        end else begin
            o_sum = w_wide[WIDTH-1:0];
            o_sat = 1'b0;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: takes operand pairs, drives one multiply per pair on
// the sequential multiplier, accumulates with saturation and presents the sum
// with sticky overflow/error flags once the last term has been folded in.
module mac_sequencer
    import mac_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mac_sequencer_if.slave   bus
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_e           r_state;
    logic             r_in_ready;
    logic             r_mul_start;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_last;
    logic [WIDTH-1:0] r_prod;
    logic             r_prod_ovf;
    logic [TMR_W-1:0] r_timer;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_err;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_sum;
    logic             w_sat;

    mac_sequencer_sat_adder u_sat_adder (
        .i_a   (r_acc),
        .i_b   (r_prod),
        .o_sum (w_sum),
        .o_sat (w_sat)
    );

    // Sequencer FSM with all datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_mul_start <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_last      <= 1'b0;
            r_prod      <= '0;
            r_prod_ovf  <= 1'b0;
            r_timer     <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a         <= bus.in_a;
                        r_b         <= bus.in_b;
                        r_last      <= bus.in_last;
                        r_in_ready  <= 1'b0;
                        r_mul_start <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Start is high for exactly the ISSUE cycle.
                    r_mul_start <= 1'b0;
                    r_state     <= ST_WAIT_CLR;
                end
                ST_WAIT_CLR: begin
                    // Let a finish left over from the previous term drop first.
                    if (!bus.mul_finish) begin
                        r_timer <= '0;
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.mul_finish) begin
                        r_prod     <= bus.mul_result;
                        r_prod_ovf <= bus.mul_overflow;
                        r_state    <= ST_ACCUM;
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        // Hung multiplier: contribute nothing, flag the error.
                        r_prod     <= '0;
                        r_prod_ovf <= 1'b0;
                        r_err      <= 1'b1;
                        r_state    <= ST_ACCUM;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_ACCUM: begin
                    r_acc <= w_sum;
                    r_ovf <= r_ovf | r_prod_ovf | w_sat;
                    if (r_count != {CNT_W{1'b1}}) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (r_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_OUTPUT;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_OUTPUT: begin
                    if (bus.out_ready) begin
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_ovf       <= 1'b0;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_mul_start <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready         = r_in_ready;
    assign bus.mul_start        = r_mul_start;
    assign bus.mul_multiplicand = r_a;
    assign bus.mul_multiplier   = r_b;
    assign bus.out_valid        = r_out_valid;
    assign bus.out_sum          = r_acc;
    assign bus.out_overflow     = r_ovf;
    assign bus.out_error        = r_err;
    assign bus.out_count        = r_count;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: behavioural Q8.7 multiplier stub,
// table of dot-product vectors, plus directed multi-cycle sequences.
module tb_mac_sequencer;
    import mac_sequencer_pkg::*;

    localparam int STUB_LAT = 16;

    typedef struct packed {
        logic [7:0]       n;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [15:0]      sum;
        logic [7:0]       cnt;
        logic             ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic stub_hang;
    int   stub_cnt;
    logic [16:0] stub_pend;
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_starts = 0;
    vec_t vecs [0:6];

    mac_sequencer_if bus ();

    mac_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Q8.7 product with round-half-up; saturates and flags overflow.
    function automatic logic [16:0] mul_model(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        logic signed [31:0] r;
        p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
        r = (p + 32'sd64) >>> 7;
        if (r > 32'sd32767)       return {1'b1, 16'h7FFF};
        else if (r < -32'sd32768) return {1'b1, 16'h8000};
        else                      return {1'b0, r[15:0]};
    endfunction

    // Multiplier stub: start clears finish; finish rises STUB_LAT cycles later unless hung.
    always @(posedge clk) begin
        if (rst) begin
            bus.mul_finish   <= 1'b0;
            bus.mul_result   <= 16'h0000;
            bus.mul_overflow <= 1'b0;
            stub_cnt         <= 0;
        end else if (bus.mul_start) begin
            bus.mul_finish <= 1'b0;
            stub_pend      <= mul_model(bus.mul_multiplicand, bus.mul_multiplier);
            stub_cnt       <= stub_hang ? 0 : STUB_LAT;
        end else if (stub_cnt == 1) begin
            bus.mul_finish   <= 1'b1;
            bus.mul_result   <= stub_pend[15:0];
            bus.mul_overflow <= stub_pend[16];
            stub_cnt         <= 0;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    // Count start pulses (cycles with mul_start high).
    always @(negedge clk) begin
        if (bus.mul_start === 1'b1) n_starts++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Offer a pair at a negedge and hold it until accepted; returns at the negedge after acceptance.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        logic accepted;
        accepted     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        for (int c = 0; c < 200 && !accepted; c++) begin
            accepted = bus.in_ready;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            n_checks++;
            n_err++;
            $display("FAIL send_accept: pair %0h x %0h never accepted", a, b);
        end
    endtask

    task automatic wait_out();
        for (int c = 0; c < 200 && !bus.out_valid; c++) @(negedge clk);
        if (!bus.out_valid) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_out: out_valid actual=0 required=1 within 200 cycles");
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_after_take", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   s0;
        v  = vecs[idx];
        s0 = n_starts;
        for (int t = 0; t < int'(v.n); t++) send(v.a[t], v.b[t], (t == int'(v.n) - 1));
        wait_out();
        check($sformatf("v%0d_sum", idx),    {16'd0, bus.out_sum},      {16'd0, v.sum});
        check($sformatf("v%0d_count", idx),  {24'd0, bus.out_count},    {24'd0, v.cnt});
        check($sformatf("v%0d_ovf", idx),    {31'd0, bus.out_overflow}, {31'd0, v.ovf});
        check($sformatf("v%0d_err", idx),    {31'd0, bus.out_error},    32'd0);
        check($sformatf("v%0d_starts", idx), n_starts - s0,             32'(v.n));
        take();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  {31'd0, bus.in_ready},       32'd1);
        check({tag, "_out_valid"}, {31'd0, bus.out_valid},      32'd0);
        check({tag, "_sum"},       {16'd0, bus.out_sum},        32'd0);
        check({tag, "_count"},     {24'd0, bus.out_count},      32'd0);
        check({tag, "_ovf"},       {31'd0, bus.out_overflow},   32'd0);
        check({tag, "_err"},       {31'd0, bus.out_error},      32'd0);
        check({tag, "_start"},     {31'd0, bus.mul_start},      32'd0);
        check({tag, "_mcand"},     {16'd0, bus.mul_multiplicand}, 32'd0);
    endtask

    initial begin
        int s0;
        int c;
        logic [15:0] held;

        vecs[0] = '{n: 8'd1, a: {16'h0, 16'h0, 16'h0, 16'h00C0}, b: {16'h0, 16'h0, 16'h0, 16'h0100},
                    sum: 16'h0180, cnt: 8'd1, ovf: 1'b0};
        vecs[1] = '{n: 8'd2, a: {16'h0, 16'h0, 16'h0100, 16'h00C0}, b: {16'h0, 16'h0, 16'hFFC0, 16'h0100},
                    sum: 16'h0100, cnt: 8'd2, ovf: 1'b0};
        vecs[2] = '{n: 8'd2, a: {16'h0, 16'h0, 16'h3200, 16'h3200}, b: {16'h0, 16'h0, 16'h0100, 16'h0100},
                    sum: 16'h7FFF, cnt: 8'd2, ovf: 1'b1};
        vecs[3] = '{n: 8'd2, a: {16'h0, 16'h0, 16'hCE00, 16'hCE00}, b: {16'h0, 16'h0, 16'h0100, 16'h0100},
                    sum: 16'h8000, cnt: 8'd2, ovf: 1'b1};
        vecs[4] = '{n: 8'd1, a: {16'h0, 16'h0, 16'h0, 16'h7F00}, b: {16'h0, 16'h0, 16'h0, 16'h0200},
                    sum: 16'h7FFF, cnt: 8'd1, ovf: 1'b1};
        vecs[5] = '{n: 8'd3, a: {16'h0, 16'h0040, 16'hFF80, 16'h0080}, b: {16'h0, 16'h0100, 16'h0080, 16'h0080},
                    sum: 16'h0080, cnt: 8'd3, ovf: 1'b0};
        vecs[6] = '{n: 8'd3, a: {16'h0, 16'hCE00, 16'h3200, 16'h3200}, b: {16'h0, 16'h0100, 16'h0100, 16'h0100},
                    sum: 16'h1BFF, cnt: 8'd3, ovf: 1'b1};

        rst           = 1'b1;
        stub_hang     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0000;
        bus.in_b      = 16'h0000;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Stray out_ready while no result is held is ignored.
        send(16'h0080, 16'h0080, 1'b0);
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        send(16'h0080, 16'h0100, 1'b1);
        wait_out();
        check("stray_ready_sum",   {16'd0, bus.out_sum},   32'h0180);
        check("stray_ready_count", {24'd0, bus.out_count}, 32'd2);
        take();

        // Result held under back-pressure; a pair offered meanwhile waits.
        send(16'h0080, 16'h0080, 1'b1);
        wait_out();
        held = bus.out_sum;
        check("hold_sum_value", {16'd0, held}, 32'h0080);
        s0 = n_starts;
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h0100;
        bus.in_b     = 16'h0100;
        bus.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", k),    {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("hold%0d_sum", k),      {16'd0, bus.out_sum},   {16'd0, held});
            check($sformatf("hold%0d_in_ready", k), {31'd0, bus.in_ready},  32'd0);
        end
        check("hold_no_start", n_starts - s0, 32'd0);
        take();
        send(16'h0100, 16'h0100, 1'b1);
        wait_out();
        check("after_hold_sum",    {16'd0, bus.out_sum},   32'h0200);
        check("after_hold_count",  {24'd0, bus.out_count}, 32'd1);
        check("after_hold_starts", n_starts - s0,          32'd1);
        take();

        // Hung multiplier: timeout after 24 WAIT_DONE cycles.
        stub_hang = 1'b1;
        send(16'h00C0, 16'h0100, 1'b1);
        c = 0;
        while (!bus.out_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("timeout_latency", c, 32'd27);
        check("timeout_err",   {31'd0, bus.out_error},    32'd1);
        check("timeout_sum",   {16'd0, bus.out_sum},      32'd0);
        check("timeout_ovf",   {31'd0, bus.out_overflow}, 32'd0);
        check("timeout_count", {24'd0, bus.out_count},    32'd1);
        take();
        stub_hang = 1'b0;
        run_vec(0);

        // Reset while term 2 is in WAIT_DONE aborts the sum.
        send(16'h0080, 16'h0080, 1'b0);
        send(16'h0100, 16'h0100, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        @(negedge clk);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
